// File: rtl/pwm_amp_sequencer.sv
// Click/pop-free power sequencing for the PWM audio amp and the tape/EAR amp:
// PWM outputs are held at midscale (mute) whenever an amplifier changes state.
//   state     | meaning
//   OFF       | amps shut down, PWM muted, waiting for enable
//   PRECHARGE | PWM muted at midscale so output caps settle before amp enable
//   SETTLE    | audio amp on, still muted while it settles
//   RUN       | audio amp on, mute follows mute_req
//   MUTING    | muted ahead of shutdown; always completes to OFF
module pwm_amp_sequencer #(
    parameter int unsigned PRECHARGE_CYC   = 2800000,
    parameter int unsigned SETTLE_CYC      = 280000,
    parameter int unsigned MUTE_CYC        = 28000,
    parameter int unsigned TAPE_SETTLE_CYC = 280000,
    parameter int unsigned CNT_W           = 24
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic mute_req,
    input  logic tape_en,
    output logic audio_sd,
    output logic tape_sd,
    output logic audio_mute,
    output logic tape_mute,
    output logic ready
);

    typedef enum logic [2:0] {OFF, PRECHARGE, SETTLE, RUN, MUTING} state_t;
    typedef enum logic [1:0] {T_OFF, T_SETTLE, T_ON, T_DOWN} tape_state_t;

    // A zero cycle count is treated as one cycle.
    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
    localparam logic [CNT_W-1:0] PRE_LD    = (PRECHARGE_CYC == 0)   ? ONE : CNT_W'(PRECHARGE_CYC);
    localparam logic [CNT_W-1:0] SET_LD    = (SETTLE_CYC == 0)      ? ONE : CNT_W'(SETTLE_CYC);
    localparam logic [CNT_W-1:0] MUTE_LD   = (MUTE_CYC == 0)        ? ONE : CNT_W'(MUTE_CYC);
    localparam logic [CNT_W-1:0] TSET_LD   = (TAPE_SETTLE_CYC == 0) ? ONE : CNT_W'(TAPE_SETTLE_CYC);

    state_t           state;
    tape_state_t      tape_state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] tape_cnt;
    logic             cnt_last;
    logic             tape_cnt_last;
    logic             audio_live;

    assign cnt_last      = (cnt <= ONE);
    assign tape_cnt_last = (tape_cnt <= ONE);
    assign audio_live    = (state == SETTLE) || (state == RUN);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= OFF;
            cnt        <= '0;
            audio_sd   <= 1'b0;
            audio_mute <= 1'b1;
            ready      <= 1'b0;
        end else begin
            case (state)
                OFF: begin
                    audio_sd   <= 1'b0;
                    audio_mute <= 1'b1;
                    ready      <= 1'b0;
                    if (enable) begin
                        cnt   <= PRE_LD;
                        state <= PRECHARGE;
                    end
                end
                PRECHARGE: begin
                    if (!enable) begin
                        state <= OFF;
                    end else if (cnt_last) begin
                        audio_sd <= 1'b1;
                        cnt      <= SET_LD;
                        state    <= SETTLE;
                    end else begin
                        cnt <= cnt - ONE;
                    end
                end
                SETTLE: begin
                    // Dropping enable wins over settle expiry.
                    if (!enable) begin
                        cnt   <= MUTE_LD;
                        state <= MUTING;
                    end else if (cnt_last) begin
                        audio_mute <= mute_req;
                        ready      <= ~mute_req;
                        state      <= RUN;
                    end else begin
                        cnt <= cnt - ONE;
                    end
                end
                RUN: begin
                    if (!enable) begin
                        audio_mute <= 1'b1;
                        ready      <= 1'b0;
                        cnt        <= MUTE_LD;
                        state      <= MUTING;
                    end else begin
                        audio_mute <= mute_req;
                        ready      <= ~mute_req;
                    end
                end
                MUTING: begin
                    if (cnt_last) begin
                        audio_sd <= 1'b0;
                        state    <= OFF;
                    end else begin
                        cnt <= cnt - ONE;
                    end
                end
                default: state <= OFF;
            endcase
        end
    end

    // Tape sub-sequencer: runs only while the audio amp is up and staying up.
    always_ff @(posedge clk) begin
        if (reset) begin
            tape_state <= T_OFF;
            tape_cnt   <= '0;
            tape_sd    <= 1'b0;
            tape_mute  <= 1'b1;
        end else if (!audio_live || !enable) begin
            // Leaving SETTLE/RUN cancels any tape sequence; tape_sd drops with audio_sd.
            tape_state <= T_OFF;
            tape_mute  <= 1'b1;
            if ((state == OFF) || (state == PRECHARGE) || ((state == MUTING) && cnt_last))
                tape_sd <= 1'b0;
        end else begin
            case (tape_state)
                T_OFF: begin
                    if (tape_en) begin
                        tape_sd    <= 1'b1;
                        tape_mute  <= 1'b1;
                        tape_cnt   <= TSET_LD;
                        tape_state <= T_SETTLE;
                    end
                end
                T_SETTLE: begin
                    if (!tape_en) begin
                        tape_mute  <= 1'b1;
                        tape_cnt   <= MUTE_LD;
                        tape_state <= T_DOWN;
                    end else if (tape_cnt_last) begin
                        tape_mute  <= mute_req;
                        tape_state <= T_ON;
                    end else begin
                        tape_cnt <= tape_cnt - ONE;
                    end
                end
                T_ON: begin
                    if (!tape_en) begin
                        tape_mute  <= 1'b1;
                        tape_cnt   <= MUTE_LD;
                        tape_state <= T_DOWN;
                    end else begin
                        tape_mute <= mute_req;
                    end
                end
                T_DOWN: begin
                    if (tape_cnt_last) begin
                        tape_sd    <= 1'b0;
                        tape_state <= T_OFF;
                    end else begin
                        tape_cnt <= tape_cnt - ONE;
                    end
                end
                default: tape_state <= T_OFF;
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_amp_sequencer.sv
// Directed bench for pwm_amp_sequencer with short cycle counts.
// outs = {audio_sd, tape_sd, audio_mute, tape_mute, ready}
module tb_pwm_amp_sequencer;

    logic clk = 1'b0;
    logic reset, enable, mute_req, tape_en;
    logic audio_sd, tape_sd, audio_mute, tape_mute, ready;
    logic [4:0] outs;
    int checks = 0;
    int errors = 0;

    assign outs = {audio_sd, tape_sd, audio_mute, tape_mute, ready};

    always #5 clk = ~clk;

    pwm_amp_sequencer #(
        .PRECHARGE_CYC(10),
        .SETTLE_CYC(5),
        .MUTE_CYC(4),
        .TAPE_SETTLE_CYC(3),
        .CNT_W(24)
    ) dut (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .mute_req(mute_req),
        .tape_en(tape_en),
        .audio_sd(audio_sd),
        .tape_sd(tape_sd),
        .audio_mute(audio_mute),
        .tape_mute(tape_mute),
        .ready(ready)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b0; mute_req = 1'b0; tape_en = 1'b0;
        tick(); tick();
        checks++;
        if (outs !== 5'b00110) begin
            errors++; $display("FAIL reset_vals: outs=%b expected %b", outs, 5'b00110);
        end
        reset = 1'b0;
        tick();
        checks++;
        if (outs !== 5'b00110) begin
            errors++; $display("FAIL reset_release_idle: outs=%b expected %b", outs, 5'b00110);
        end
    endtask

    // Edge 0 is the edge where OFF samples enable=1.
    task automatic test_powerup();
        enable = 1'b1;
        for (int k = 0; k <= 15; k++) begin
            logic [4:0] exp;
            tick();
            exp = (k < 10) ? 5'b00110 : (k < 15) ? 5'b10110 : 5'b10011;
            checks++;
            if (outs !== exp) begin
                errors++; $display("FAIL powerup_e%0d: outs=%b expected %b", k, outs, exp);
            end
        end
    endtask

    task automatic test_tape_on();
        tape_en = 1'b1;
        for (int k = 0; k <= 3; k++) begin
            logic [4:0] exp;
            tick();
            exp = (k < 3) ? 5'b11011 : 5'b11001;
            checks++;
            if (outs !== exp) begin
                errors++; $display("FAIL tape_on_e%0d: outs=%b expected %b", k, outs, exp);
            end
        end
    endtask

    task automatic test_user_mute();
        mute_req = 1'b1;
        tick();
        checks++;
        if (outs !== 5'b11110) begin
            errors++; $display("FAIL user_mute_on: outs=%b expected %b", outs, 5'b11110);
        end
        mute_req = 1'b0;
        tick();
        checks++;
        if (outs !== 5'b11001) begin
            errors++; $display("FAIL user_mute_off: outs=%b expected %b", outs, 5'b11001);
        end
    endtask

    // tape_en re-pulse sampled at D+1 and D+2 must be ignored.
    task automatic test_tape_off();
        tape_en = 1'b0;
        for (int k = 0; k <= 5; k++) begin
            logic [4:0] exp;
            tick();
            tape_en = (k == 0 || k == 1);
            exp = (k < 4) ? 5'b11011 : 5'b10011;
            checks++;
            if (outs !== exp) begin
                errors++; $display("FAIL tape_off_e%0d: outs=%b expected %b", k, outs, exp);
            end
        end
        tape_en = 1'b0;
    endtask

    // Tape settle pending when MUTING starts: cancelled, tape_sd falls with audio_sd.
    task automatic test_shutdown();
        tape_en = 1'b1;
        tick();
        checks++;
        if (outs !== 5'b11011) begin
            errors++; $display("FAIL shutdown_tape_start: outs=%b expected %b", outs, 5'b11011);
        end
        tick();
        enable = 1'b0;
        for (int k = 0; k <= 5; k++) begin
            logic [4:0] exp;
            tick();
            exp = (k < 4) ? 5'b11110 : 5'b00110;
            checks++;
            if (outs !== exp) begin
                errors++; $display("FAIL shutdown_e%0d: outs=%b expected %b", k, outs, exp);
            end
        end
        tape_en = 1'b0;
    endtask

    task automatic test_muting_toggle_restart();
        enable = 1'b1;
        for (int k = 0; k <= 15; k++) tick();
        checks++;
        if (outs !== 5'b10011) begin
            errors++; $display("FAIL toggle_reach_run: outs=%b expected %b", outs, 5'b10011);
        end
        enable = 1'b0;
        tick();
        enable = 1'b1;
        // Relative to MUTING entry edge E: off at E+4, restart sampled at E+5, sd at E+15.
        for (int k = 1; k <= 15; k++) begin
            logic [4:0] exp;
            tick();
            exp = (k < 4) ? 5'b10110 : (k < 15) ? 5'b00110 : 5'b10110;
            checks++;
            if (outs !== exp) begin
                errors++; $display("FAIL toggle_restart_e%0d: outs=%b expected %b", k, outs, exp);
            end
        end
        for (int k = 16; k <= 20; k++) tick();
        checks++;
        if (outs !== 5'b10011) begin
            errors++; $display("FAIL toggle_rerun: outs=%b expected %b", outs, 5'b10011);
        end
    endtask

    task automatic test_reset_in_run();
        tape_en = 1'b1;
        for (int k = 0; k <= 3; k++) tick();
        checks++;
        if (outs !== 5'b11001) begin
            errors++; $display("FAIL rst_run_tape_up: outs=%b expected %b", outs, 5'b11001);
        end
        reset = 1'b1;
        tick();
        checks++;
        if (outs !== 5'b00110) begin
            errors++; $display("FAIL rst_run_vals: outs=%b expected %b", outs, 5'b00110);
        end
        reset = 1'b0; enable = 1'b0; tape_en = 1'b0;
        tick();
        checks++;
        if (outs !== 5'b00110) begin
            errors++; $display("FAIL rst_run_after: outs=%b expected %b", outs, 5'b00110);
        end
    endtask

    task automatic test_abort_precharge();
        enable = 1'b1;
        for (int k = 0; k <= 4; k++) tick();
        enable = 1'b0;
        for (int k = 5; k <= 15; k++) begin
            tick();
            checks++;
            if (outs !== 5'b00110) begin
                errors++; $display("FAIL abort_pre_e%0d: outs=%b expected %b", k, outs, 5'b00110);
            end
        end
    endtask

    task automatic test_abort_settle();
        enable = 1'b1;
        for (int k = 0; k <= 10; k++) tick();
        checks++;
        if (outs !== 5'b10110) begin
            errors++; $display("FAIL abort_settle_sd_up: outs=%b expected %b", outs, 5'b10110);
        end
        tick();
        enable = 1'b0;
        for (int k = 12; k <= 16; k++) begin
            logic [4:0] exp;
            tick();
            exp = (k < 16) ? 5'b10110 : 5'b00110;
            checks++;
            if (outs !== exp) begin
                errors++; $display("FAIL abort_settle_e%0d: outs=%b expected %b", k, outs, exp);
            end
        end
    endtask

    // enable drops on the very edge the settle count expires: MUTING, not RUN.
    task automatic test_back_to_back();
        enable = 1'b1;
        for (int k = 0; k <= 14; k++) tick();
        checks++;
        if (outs !== 5'b10110) begin
            errors++; $display("FAIL b2b_settle: outs=%b expected %b", outs, 5'b10110);
        end
        enable = 1'b0;
        for (int k = 15; k <= 19; k++) begin
            logic [4:0] exp;
            tick();
            exp = (k < 19) ? 5'b10110 : 5'b00110;
            checks++;
            if (outs !== exp) begin
                errors++; $display("FAIL b2b_e%0d: outs=%b expected %b", k, outs, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_powerup();
        test_tape_on();
        test_user_mute();
        test_tape_off();
        test_shutdown();
        test_muting_toggle_restart();
        test_reset_in_run();
        test_abort_precharge();
        test_abort_settle();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
